// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared default widths and FSM state encodings for the data-memory responder
package dmem_responder_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, per-byte write enables, registered read data, no reset
//  clk   in  clock
//  en    in  access enable for this cycle
//  we    in  1 = write enabled bytes, 0 = read into rdata
//  be    in  byte enables for writes
//  addr  in  word address
//  wdata in  write data
//  rdata out read data, updated only on enabled reads
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W/8; i++)
                if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            if (!we) rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: CPU load/store responder with programmable wait states in front of a word RAM
//  clk, reset             clock, asynchronous active-high reset
//  req_valid/req_ready    request handshake; req_we/addr/wdata/be are the request fields
//  resp_valid/resp_ready  response handshake; resp_rdata is load data, resp_err flags out-of-range
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]          state;
    logic [3:0]          cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic                load_ok;
    logic                in_range;
    logic                fire;
    logic [DATA_W-1:0]   ram_q;

    assign in_range   = 32'(addr_q) < 32'(DEPTH);
    assign fire       = state == S_WAIT && cnt == 4'd0;
    assign req_ready  = state == S_IDLE && !reset;
    assign resp_valid = state == S_RESP;
    // The RAM read register only updates on an enabled read, so it holds the load data through RESP.
    assign resp_rdata = load_ok ? ram_q : '0;

    dmem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (fire && in_range),
        .we    (we_q),
        .be    (be_q),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            load_ok  <= 1'b0;
            resp_err <= 1'b0;
        end else if (state == S_IDLE) begin
            if (req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt     <= 4'(WAIT_CYCLES);
                state   <= S_WAIT;
            end
        end else if (state == S_WAIT) begin
            if (cnt == 4'd0) begin
                load_ok  <= in_range && !we_q;
                resp_err <= !in_range;
                state    <= S_RESP;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (resp_ready) begin
            load_ok  <= 1'b0;
            resp_err <= 1'b0;
            state    <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven and scoreboard-checked bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 0;
    logic        reset = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic        req_we = 0;
    logic [7:0]  req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        resp_valid;
    logic        resp_ready = 1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vt[12];

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: each handshake at the coming rising edge consumes one expected response.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got rdata=%h err=%b expected no response", resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    failures++;
                    $display("FAIL sb_resp: got rdata=%h err=%b expected rdata=%h err=%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        req_valid = 1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check(name, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_resp(input string name, output int n);
        n = 0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check(name, 32'(resp_valid), 32'd1);
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        exp_t e;
        drive(v);
        wait_ready("accept_timeout");
        e.rdata = v.rdata;
        e.err   = v.err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble the request pins: the latched copy must be used.
        req_valid = 0;
        req_we    = ~v.we;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_be    = ~v.be;
        wait_resp("resp_timeout", n);
        check("latency", 32'(n), 32'd3);
        @(posedge clk); #1;
        check("post_resp_valid", 32'(resp_valid), 32'd0);
        check("post_resp_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        vt[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 8'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0};
        vt[3]  = '{1'b0, 8'h10, 32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
        vt[4]  = '{1'b0, 8'hC0, 32'h0,        4'h0, 32'h0, 1'b1};
        vt[5]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vt[6]  = '{1'b1, 8'h7F, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        vt[7]  = '{1'b1, 8'h7F, 32'h11223344, 4'hA, 32'h0, 1'b0};
        vt[8]  = '{1'b0, 8'h7F, 32'h0,        4'h0, 32'h11FE330D, 1'b0};
        vt[9]  = '{1'b1, 8'h80, 32'h12345678, 4'hF, 32'h0, 1'b1};
        vt[10] = '{1'b1, 8'h20, 32'h55AA55AA, 4'hF, 32'h0, 1'b0};
        vt[11] = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h55AA55AA, 1'b0};

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        reset = 0;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) do_txn(vt[i]);

        // Back-pressure: response held while a second request waits.
        resp_ready = 0;
        drive(vt[5]);
        wait_ready("bp_accept");
        e.rdata = 32'hDEADBEAA; e.err = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive(vt[8]);
        wait_resp("bp_resp", n);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, 32'hDEADBEAA);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        e.rdata = 32'h11FE330D; e.err = 1'b0;
        exp_q.push_back(e);
        resp_ready = 1;
        @(posedge clk); #1;
        check("bp_done_valid", 32'(resp_valid), 32'd0);
        check("bp_next_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        check("bp_next_accepted", 32'(req_ready), 32'd0);
        wait_resp("bp_next_resp", n);
        @(posedge clk); #1;

        // Reset one cycle into WAIT of a store: nothing written, no response.
        drive('{1'b1, 8'h20, 32'h0BADF00D, 4'hF, 32'h0, 1'b0});
        wait_ready("rw_accept");
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        #1;
        check("rw_req_ready", 32'(req_ready), 32'd0);
        check("rw_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        #1;
        check("rw_idle", 32'(req_ready), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check("rw_no_resp", 32'(resp_valid), 32'd0);
        end
        do_txn(vt[11]);

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
